// File: rtl/ks_add_sequencer.sv
// Time-shares one 8-bit Kogge-Stone adder among NREQ requesters.
// Ports: clk, rst_n, req_valid/ready/a/b/cin (per requester), rsp_valid/ready/id/sum/cout.

module kogge_stone (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [8:0] s,
  output logic [7:0] c
);

  logic [7:0] p0;
  logic [7:0] gl;
  logic [7:0] pl;
  logic [7:0] gn;
  logic [7:0] pn;

  // cin is folded into bit 0's generate, so the final group
  // generate at bit i is the carry out of bit i.
  always_comb begin
    p0 = a ^ b;
    gl = (a & b) | {7'b0, p0[0] & cin};
    pl = p0;
    gn = gl;
    pn = pl;
    for (int l = 0; l < 3; l++) begin
      gn = gl;
      pn = pl;
      for (int i = (1 << l); i < 8; i++) begin
        gn[i] = gl[i] | (pl[i] & gl[i-(1<<l)]);
        pn[i] = pl[i] & pl[i-(1<<l)];
      end
      gl = gn;
      pl = pn;
    end
    c = gl;
    s = {gl[7], p0 ^ {gl[6:0], cin}};
  end

endmodule

module ks_add_sequencer #(
  parameter int NREQ   = 4,
  parameter int NBYTES = 4,
  parameter int IW     = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*8*NBYTES-1:0] req_a,
  input  logic [NREQ*8*NBYTES-1:0] req_b,
  input  logic [NREQ-1:0]          req_cin,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IW-1:0]            rsp_id,
  output logic [8*NBYTES-1:0]      rsp_sum,
  output logic                     rsp_cout
);

  localparam int W  = 8 * NBYTES;
  localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [NBYTES-1:0][7:0] a_q;
  logic [NBYTES-1:0][7:0] b_q;
  logic [NBYTES-1:0][7:0] sum_q;
  logic                   carry_q;
  logic                   cout_q;
  logic [BW-1:0]          idx_q;
  logic [IW-1:0]          id_q;
  logic [IW-1:0]          last_q;

  logic                   gnt_any;
  logic [IW-1:0]          gnt_id;
  logic [NREQ-1:0]        gnt_oh;
  logic [W-1:0]           sel_a;
  logic [W-1:0]           sel_b;
  logic                   sel_c;
  logic                   accept;
  logic                   last_byte;

  logic [7:0]             ks_a;
  logic [7:0]             ks_b;
  logic [8:0]             ks_s;
  logic [7:0]             ks_c;
  logic                   unused_c;

  // Round-robin: pick the valid requester closest after last grant.
  always_comb begin
    int d;
    int best;
    d       = 0;
    best    = NREQ;
    gnt_id  = '0;
    gnt_any = |req_valid;
    for (int i = 0; i < NREQ; i++) begin
      d = (i - int'(last_q) - 1 + 2 * NREQ) % NREQ;
      if (req_valid[i] && d < best) begin
        best   = d;
        gnt_id = IW'(i);
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_oh[i] = gnt_any && (gnt_id == IW'(i));
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_c = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
        sel_c = req_cin[i];
      end
    end
  end

  assign accept    = (state_q == IDLE) && gnt_any;
  // rst_n gate keeps req_ready low while reset is held.
  assign req_ready = (accept && rst_n) ? gnt_oh : '0;
  assign last_byte = (idx_q == BW'(NBYTES - 1));

  assign ks_a = a_q[idx_q];
  assign ks_b = b_q[idx_q];

  kogge_stone u_ks (
    .a   (ks_a),
    .b   (ks_b),
    .cin (carry_q),
    .s   (ks_s),
    .c   (ks_c)
  );

  assign unused_c = ^ks_c;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_any) state_d = RUN;
      RUN:     if (last_byte) state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
      id_q    <= '0;
      last_q  <= IW'(NREQ - 1);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            carry_q <= sel_c;
            id_q    <= gnt_id;
            last_q  <= gnt_id;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q[idx_q] <= ks_s[7:0];
          carry_q      <= ks_s[8];
          idx_q        <= idx_q + 1'b1;
          if (last_byte) begin
            cout_q <= ks_s[8];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_ks_add_sequencer.sv
// Randomized self-checking bench for ks_add_sequencer.
// Reference model: exact integer sum plus round-robin pick rule.

module tb_ks_add_sequencer;

  localparam int NREQ   = 4;
  localparam int NBYTES = 4;
  localparam int IW     = 2;
  localparam int W      = 8 * NBYTES;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_cin = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IW-1:0]     rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;

  int total = 0;
  int bad   = 0;
  int mlast = NREQ - 1;

  always #5 clk = ~clk;

  ks_add_sequencer #(
    .NREQ   (NREQ),
    .NBYTES (NBYTES),
    .IW     (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  function automatic int rr_pick(logic [NREQ-1:0] m, int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (m[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_ops(input int i, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic c);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = c;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mlast = NREQ - 1;
  endtask

  // One transaction: predicts grant and result, checks accept, latency,
  // stability under hold cycles of backpressure, and the handshake.
  task automatic xact(input string nm, input bit drop, input bit scr,
                      input int hold, output int got);
    int eg;
    int lat;
    bit seen;
    bit rdy_seen;
    logic [W:0] er;
    logic [NREQ-1:0] gm;
    eg  = rr_pick(req_valid, mlast);
    got = -1;
    if (eg < 0) begin
      total++;
      bad++;
      $display("FAIL %s nomask: req_valid=%b", nm, req_valid);
      return;
    end
    er = {1'b0, req_a[eg*W +: W]} + {1'b0, req_b[eg*W +: W]}
       + (W+1)'(req_cin[eg]);
    gm = '0;
    gm[eg] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (req_ready != '0) begin
        for (int i = NREQ - 1; i >= 0; i--) if (req_ready[i]) got = i;
        total++;
        if (req_ready !== gm) begin
          bad++;
          $display("FAIL %s grant: req_ready=%b want=%b", nm, req_ready, gm);
        end
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    if (got < 0) begin
      total++;
      bad++;
      $display("FAIL %s accept timeout: req_ready=%b want=%b", nm, req_ready, gm);
      return;
    end
    mlast = eg;
    #1;
    if (scr) set_ops(eg, $urandom, $urandom, 1'($urandom));
    if (drop) req_valid[eg] = 1'b0;
    lat = 0;
    seen = 1'b0;
    rdy_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      lat++;
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      if (req_ready != '0) rdy_seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s rsp timeout: rsp_valid=%b want=1", nm, rsp_valid);
      return;
    end
    total++;
    if (lat != NBYTES + 1) begin
      bad++;
      $display("FAIL %s latency: got=%0d want=%0d", nm, lat, NBYTES + 1);
    end
    total++;
    if (rdy_seen) begin
      bad++;
      $display("FAIL %s ready in run: got=1 want=0", nm);
    end
    total++;
    if (rsp_sum !== er[W-1:0]) begin
      bad++;
      $display("FAIL %s sum: got=%h want=%h", nm, rsp_sum, er[W-1:0]);
    end
    total++;
    if (rsp_cout !== er[W]) begin
      bad++;
      $display("FAIL %s cout: got=%b want=%b", nm, rsp_cout, er[W]);
    end
    total++;
    if (rsp_id !== IW'(eg)) begin
      bad++;
      $display("FAIL %s id: got=%0d want=%0d", nm, rsp_id, eg);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_sum !== er[W-1:0] ||
          rsp_id !== IW'(eg) || req_ready !== '0) begin
        bad++;
        $display("FAIL %s hold%0d: v=%b sum=%h id=%0d rdy=%b want v=1 sum=%h id=%0d rdy=0",
                 nm, h, rsp_valid, rsp_sum, rsp_id, req_ready, er[W-1:0], eg);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s handshake: rsp_valid=%b want=0", nm, rsp_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    req_valid = '1;
    @(negedge clk);
    #1;
    total++;
    if (req_ready !== '0) begin
      bad++;
      $display("FAIL reset req_ready: got=%b want=0", req_ready);
    end
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset rsp_valid: got=%b want=0", rsp_valid);
    end
    total++;
    if (rsp_sum !== '0) begin
      bad++;
      $display("FAIL reset rsp_sum: got=%h want=0", rsp_sum);
    end
    total++;
    if (rsp_cout !== 1'b0 || rsp_id !== '0) begin
      bad++;
      $display("FAIL reset cout/id: got=%b/%0d want=0/0", rsp_cout, rsp_id);
    end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mlast = NREQ - 1;
  endtask

  task automatic test_single();
    int g;
    set_ops(0, 32'h00000041, 32'h00000054, 1'b1);
    req_valid = 4'b0001;
    xact("single", 1'b1, 1'b0, 0, g);
  endtask

  task automatic test_carry();
    int g;
    set_ops(1, 32'h000000FF, 32'h00000001, 1'b0);
    req_valid = 4'b0010;
    xact("carry_byte", 1'b1, 1'b0, 0, g);
    set_ops(2, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    req_valid = 4'b0100;
    xact("overflow", 1'b1, 1'b0, 0, g);
  endtask

  task automatic test_round_robin();
    int g;
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, $urandom, $urandom, 1'($urandom));
    req_valid = '1;
    for (int n = 0; n < 5; n++) begin
      xact("rr", 1'b0, 1'b1, 0, g);
      total++;
      if (g != order[n]) begin
        bad++;
        $display("FAIL rr order%0d: got=%0d want=%0d", n, g, order[n]);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    int g;
    set_ops(0, $urandom, $urandom, 1'($urandom));
    set_ops(2, $urandom, $urandom, 1'($urandom));
    req_valid = 4'b0101;
    xact("bp", 1'b1, 1'b0, 3, g);
    req_valid = '0;
  endtask

  task automatic test_capture();
    int g;
    set_ops(3, 32'h2B1C2A41, 32'h905B0C0D, 1'b0);
    req_valid = 4'b1000;
    xact("capture", 1'b1, 1'b1, 0, g);
  endtask

  task automatic test_reset_mid_run();
    int g;
    bit stale;
    set_ops(1, $urandom, $urandom, 1'($urandom));
    req_valid = 4'b0010;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL midrst accept: req_ready=%b want=0010", req_ready);
    end
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (req_ready !== '0 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst ctl: rdy=%b v=%b want 0/0", req_ready, rsp_valid);
    end
    total++;
    if (rsp_sum !== '0 || rsp_cout !== 1'b0 || rsp_id !== '0) begin
      bad++;
      $display("FAIL midrst data: sum=%h cout=%b id=%0d want 0", rsp_sum, rsp_cout, rsp_id);
    end
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    mlast = NREQ - 1;
    stale = 1'b0;
    repeat (8) begin
      #1;
      if (rsp_valid) stale = 1'b1;
      @(negedge clk);
    end
    total++;
    if (stale) begin
      bad++;
      $display("FAIL midrst stale rsp: got=1 want=0");
    end
    for (int i = 0; i < 3; i++) set_ops(i, $urandom, $urandom, 1'($urandom));
    req_valid = 4'b0111;
    xact("rst_prio", 1'b1, 1'b1, 0, g);
    total++;
    if (g != 0) begin
      bad++;
      $display("FAIL rst_prio grant: got=%0d want=0", g);
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    int g;
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < NREQ; i++) set_ops(i, $urandom, $urandom, 1'($urandom));
      req_valid = 4'($urandom_range(1, 15));
      xact("rand", 1'b1, 1'b1, $urandom_range(0, 2), g);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_round_robin();
    test_backpressure();
    test_capture();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
